regfile_write_arbiter: RTL

Round-robin arbiter sharing the single register-file write port (`we3`/`wa3`/`wd3`) among up to four requesters: the CPU writeback path, the debug/button write path (fed from the input limiter) and spare ports. Each cycle it grants at most one valid request and registers the winning address and data onto the write port. Writes to register 0 are suppressed.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter_rr_picker.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 66 ++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Imported by the interface, the picker and the top level.
package regfile_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  localparam int R0_ADDR  = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester bundle plus the registered register-file write port.
// The master side is the requester pool; the slave side is the arbiter.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  localparam int IDW = $clog2(NREQ);

  logic                     hold;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     we3;
  logic [AW-1:0]            wa3;
  logic [DW-1:0]            wd3;
  logic [IDW-1:0]           grant_id;
  logic [7:0]               r0_drops;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, we3, wa3, wd3, grant_id, r0_drops
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, we3, wa3, wd3, grant_id, r0_drops
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod NREQ.
// Works for any NREQ, including non-powers of two.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  // Scan from the farthest offset back to ptr so the closest hit is written last.
  always_comb begin : pick
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[IDW'(j)]) begin
        grant          = '0;
        grant[IDW'(j)] = 1'b1;
        idx            = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port (we3/wa3/wd3).
// Writes to register 0 are accepted but suppressed and counted.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  next_ptr;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            fire;
  logic            win_is_r0;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // Reset gates ready combinationally so nothing handshakes while the port is cleared.
  assign bus.req_ready = (reset || bus.hold) ? '0 : grant;
  assign fire          = |bus.req_ready;
  assign win_addr      = bus.req_addr[win_idx];
  assign win_data      = bus.req_data[win_idx];
  assign win_is_r0     = (win_addr == AW'(R0_ADDR));
  assign next_ptr      = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      bus.we3      <= 1'b0;
      bus.wa3      <= '0;
      bus.wd3      <= '0;
      bus.grant_id <= '0;
      bus.r0_drops <= '0;
    end else if (fire) begin
      rr_ptr       <= next_ptr;
      bus.grant_id <= win_idx;
      bus.wa3      <= win_addr;
      bus.wd3      <= win_data;
      bus.we3      <= !win_is_r0;
      if (win_is_r0 && bus.r0_drops != 8'hFF) begin
        bus.r0_drops <= bus.r0_drops + 8'd1;
      end
    end else begin
      bus.we3 <= 1'b0;
    end
  end

endmodule
